// File: rtl/cpu_pkg.sv
// Shared types for the VeriRISC sequencer: opcodes, phase, FSM state and
// the bit layout of the nine-wide datapath control vector.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   typedef logic [2:0] phase_t;

   typedef enum logic {
      ST_HALTED = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   // Control vector layout, sel in the MSB down to wr in the LSB
   localparam int unsigned CTL_W      = 9;
   localparam int unsigned CTL_SEL    = 8;
   localparam int unsigned CTL_RD     = 7;
   localparam int unsigned CTL_LD_IR  = 6;
   localparam int unsigned CTL_INC_PC = 5;
   localparam int unsigned CTL_HALT   = 4;
   localparam int unsigned CTL_LD_PC  = 3;
   localparam int unsigned CTL_DATA_E = 2;
   localparam int unsigned CTL_LD_AC  = 1;
   localparam int unsigned CTL_WR     = 0;

   function automatic logic is_alu(input opcode_t op);
      return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
   endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Three-bit instruction phase counter with enable and synchronous clear.
module seq_phase_counter
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_,
   input  logic   en,
   input  logic   clr,
   output phase_t count
);

   // Clear wins over enable so a halt always parks the counter at zero
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         count <= 3'd0;
      else if (clr)
         count <= 3'd0;
      else if (en)
         count <= count + 3'd1;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// VeriRISC sequencer: phase FSM, control decode, memory-ready stall,
// halt/run handshake and retired-instruction counter.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter bit          STALL_EN     = 1'b1,
   parameter bit          RESET_HALTED = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [2:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             run,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             halt,
   output logic             ld_pc,
   output logic             data_e,
   output logic             ld_ac,
   output logic             wr,
   output logic [2:0]       phase,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam state_t RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

   opcode_t          op;
   state_t           state_q;
   state_t           state_d;
   logic             ph_en_c;
   logic             ph_clr_c;
   logic             retire_c;
   logic             stall_pt_c;
   logic             stall_c;
   logic [CTL_W-1:0] ctl_c;

   assign op = opcode_t'(opcode);

   seq_phase_counter u_phase (
      .clk   (clk),
      .rst_  (rst_),
      .en    (ph_en_c),
      .clr   (ph_clr_c),
      .count (phase)
   );

   // Memory access completes at phase 3 (fetch) and phase 7 for ALU/STO
   assign stall_pt_c = (phase == 3'd3) ||
                       ((phase == 3'd7) && (is_alu(op) || (op == OP_STO)));
   assign stall_c    = STALL_EN && (state_q == ST_RUN) && stall_pt_c && !mem_ready;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         state_q <= RST_STATE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ph_en_c  = 1'b0;
      ph_clr_c = 1'b0;
      retire_c = 1'b0;
      case (state_q)
         ST_HALTED: begin
            ph_clr_c = 1'b1;
            if (run)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if ((phase == 3'd4) && (op == OP_HLT)) begin
               state_d  = ST_HALTED;
               ph_clr_c = 1'b1;
            end else if (!stall_c) begin
               ph_en_c  = 1'b1;
               retire_c = (phase == 3'd7);
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   // Control decode from registered state/phase plus live opcode/zero
   always_comb begin
      ctl_c = '0;
      if (state_q == ST_RUN) begin
         case (phase)
            3'd0: ctl_c[CTL_SEL] = 1'b1;
            3'd1: begin
               ctl_c[CTL_SEL] = 1'b1;
               ctl_c[CTL_RD]  = 1'b1;
            end
            3'd2, 3'd3: begin
               ctl_c[CTL_SEL]   = 1'b1;
               ctl_c[CTL_RD]    = 1'b1;
               ctl_c[CTL_LD_IR] = 1'b1;
            end
            3'd4: begin
               ctl_c[CTL_INC_PC] = 1'b1;
               ctl_c[CTL_HALT]   = (op == OP_HLT);
            end
            3'd5: ctl_c[CTL_RD] = is_alu(op);
            3'd6: begin
               ctl_c[CTL_RD]     = is_alu(op);
               ctl_c[CTL_DATA_E] = (op == OP_STO);
               ctl_c[CTL_LD_PC]  = (op == OP_JMP);
               ctl_c[CTL_INC_PC] = (op == OP_SKZ) && zero;
            end
            3'd7: begin
               ctl_c[CTL_RD]     = is_alu(op);
               ctl_c[CTL_LD_AC]  = is_alu(op);
               ctl_c[CTL_DATA_E] = (op == OP_STO);
               ctl_c[CTL_WR]     = (op == OP_STO);
               ctl_c[CTL_LD_PC]  = (op == OP_JMP);
            end
            default: ctl_c = '0;
         endcase
      end
   end

   assign sel    = ctl_c[CTL_SEL];
   assign rd     = ctl_c[CTL_RD];
   assign ld_ir  = ctl_c[CTL_LD_IR];
   assign inc_pc = ctl_c[CTL_INC_PC];
   assign halt   = ctl_c[CTL_HALT];
   assign ld_pc  = ctl_c[CTL_LD_PC];
   assign data_e = ctl_c[CTL_DATA_E];
   assign ld_ac  = ctl_c[CTL_LD_AC];
   assign wr     = ctl_c[CTL_WR];
   assign halted = (state_q == ST_HALTED);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         instr_cnt <= '0;
      else if (retire_c)
         instr_cnt <= instr_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: three parameterisations driven from one
// shared stimulus stream, each held in reset while another is exercised.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic [2:0]  opcode;
   logic        zero, mem_ready, run;
   logic        rst_a, rst_b, rst_c;

   logic [8:0]  ctl_a, ctl_b, ctl_c;
   logic [2:0]  phase_a, phase_b, phase_c;
   logic        halted_a, halted_b, halted_c;
   logic [15:0] cnt_a, cnt_b;
   logic [1:0]  cnt_c;

   logic [8:0]  ctl_x;
   logic [2:0]  phase_x;
   logic        halted_x;
   logic [15:0] cnt_x;
   int          cur;

   int n_run  = 0;
   int n_fail = 0;

   // Expected control vectors {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
   // rows: 0 ALU, 1 STO, 2 JMP, 3 SKZ zero=0, 4 SKZ zero=1, 5 HLT
   logic [8:0] tab [6][8] = '{
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010},
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101},
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000100000, 9'b000000000, 9'b000001000, 9'b000001000},
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000},
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000},
      '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000110000, 9'b000000000, 9'b000000000, 9'b000000000}
   };

   always #5 clk = ~clk;

   cpu_sequencer #(.STALL_EN(1'b0), .RESET_HALTED(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_(rst_a), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .run(run),
      .sel(ctl_a[8]), .rd(ctl_a[7]), .ld_ir(ctl_a[6]), .inc_pc(ctl_a[5]),
      .halt(ctl_a[4]), .ld_pc(ctl_a[3]), .data_e(ctl_a[2]), .ld_ac(ctl_a[1]),
      .wr(ctl_a[0]), .phase(phase_a), .halted(halted_a), .instr_cnt(cnt_a)
   );

   cpu_sequencer #(.STALL_EN(1'b1), .RESET_HALTED(1'b1), .CNT_W(16)) dut_b (
      .clk(clk), .rst_(rst_b), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .run(run),
      .sel(ctl_b[8]), .rd(ctl_b[7]), .ld_ir(ctl_b[6]), .inc_pc(ctl_b[5]),
      .halt(ctl_b[4]), .ld_pc(ctl_b[3]), .data_e(ctl_b[2]), .ld_ac(ctl_b[1]),
      .wr(ctl_b[0]), .phase(phase_b), .halted(halted_b), .instr_cnt(cnt_b)
   );

   cpu_sequencer #(.STALL_EN(1'b0), .RESET_HALTED(1'b0), .CNT_W(2)) dut_c (
      .clk(clk), .rst_(rst_c), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .run(run),
      .sel(ctl_c[8]), .rd(ctl_c[7]), .ld_ir(ctl_c[6]), .inc_pc(ctl_c[5]),
      .halt(ctl_c[4]), .ld_pc(ctl_c[3]), .data_e(ctl_c[2]), .ld_ac(ctl_c[1]),
      .wr(ctl_c[0]), .phase(phase_c), .halted(halted_c), .instr_cnt(cnt_c)
   );

   always_comb begin
      ctl_x    = ctl_a;
      phase_x  = phase_a;
      halted_x = halted_a;
      cnt_x    = cnt_a;
      case (cur)
         1: begin
            ctl_x = ctl_b; phase_x = phase_b; halted_x = halted_b; cnt_x = cnt_b;
         end
         2: begin
            ctl_x = ctl_c; phase_x = phase_c; halted_x = halted_c; cnt_x = 16'(cnt_c);
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; checks phase and controls for nph phases
   task automatic do_instr(input logic [2:0] op, input int kind, input int nph,
                           input logic [7:0] mr, input string name);
      for (int ph = 0; ph < nph; ph++) begin
         opcode    = op;
         mem_ready = mr[ph];
         #1;
         chk($sformatf("%s ph%0d phase", name, ph), 32'(phase_x), 32'(ph));
         chk($sformatf("%s ph%0d ctl", name, ph), 32'(ctl_x), 32'(tab[kind][ph]));
         @(negedge clk);
      end
   endtask

   initial begin
      opcode = 3'd0; zero = 1'b0; mem_ready = 1'b1; run = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; cur = 0;

      // Running-from-reset, unstalled configuration
      @(negedge clk);
      #1;
      chk("a rst phase", 32'(phase_x), 32'd0);
      chk("a rst halted", 32'(halted_x), 32'd0);
      chk("a rst cnt", 32'(cnt_x), 32'd0);
      chk("a rst ctl", 32'(ctl_x), 32'h100);
      rst_a = 1'b1;
      do_instr(3'd2, 0, 8, 8'hFF, "a add");
      do_instr(3'd6, 1, 8, 8'hFF, "a sto");
      #1 chk("a cnt after 16", 32'(cnt_x), 32'd2);
      do_instr(3'd3, 0, 8, 8'hFF, "a and");
      do_instr(3'd4, 0, 8, 8'hFF, "a xor");
      do_instr(3'd5, 0, 8, 8'h00, "a lda nomr");
      do_instr(3'd7, 2, 8, 8'hFF, "a jmp");
      zero = 1'b0;
      do_instr(3'd1, 3, 8, 8'hFF, "a skz z0");
      zero = 1'b1;
      do_instr(3'd1, 4, 8, 8'hFF, "a skz z1");
      zero = 1'b0;
      #1 chk("a cnt before hlt", 32'(cnt_x), 32'd8);

      // HLT with run held high: must still pass through HALTED
      run = 1'b1;
      do_instr(3'd0, 5, 5, 8'hFF, "a hlt");
      #1;
      chk("a hlt halted", 32'(halted_x), 32'd1);
      chk("a hlt phase", 32'(phase_x), 32'd0);
      chk("a hlt ctl", 32'(ctl_x), 32'd0);
      chk("a hlt cnt", 32'(cnt_x), 32'd8);
      @(negedge clk);
      #1;
      chk("a resume halted", 32'(halted_x), 32'd0);
      chk("a resume phase", 32'(phase_x), 32'd0);
      chk("a resume ctl", 32'(ctl_x), 32'h100);
      chk("a resume cnt", 32'(cnt_x), 32'd8);
      run = 1'b0;
      rst_a = 1'b0;

      // Reset-halted configuration with stalls enabled
      cur = 1;
      #1;
      chk("b rst halted", 32'(halted_x), 32'd1);
      chk("b rst ctl", 32'(ctl_x), 32'd0);
      chk("b rst phase", 32'(phase_x), 32'd0);
      chk("b rst cnt", 32'(cnt_x), 32'd0);
      rst_b = 1'b1;
      @(negedge clk);
      #1 chk("b idle halted", 32'(halted_x), 32'd1);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      #1;
      chk("b run halted", 32'(halted_x), 32'd0);
      chk("b run phase", 32'(phase_x), 32'd0);
      chk("b run ctl", 32'(ctl_x), 32'h100);

      // LDA: 3 stall cycles at phase 3, 2 at phase 7 -> 13 cycles
      opcode = 3'd5;
      for (int ph = 0; ph < 3; ph++) begin
         mem_ready = (ph != 1);
         #1;
         chk($sformatf("b lda ph%0d phase", ph), 32'(phase_x), 32'(ph));
         chk($sformatf("b lda ph%0d ctl", ph), 32'(ctl_x), 32'(tab[0][ph]));
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         chk($sformatf("b lda st3 %0d phase", i), 32'(phase_x), 32'd3);
         chk($sformatf("b lda st3 %0d ctl", i), 32'(ctl_x), 32'h1C0);
         @(negedge clk);
      end
      for (int ph = 4; ph < 7; ph++) begin
         mem_ready = (ph != 5);
         #1;
         chk($sformatf("b lda ph%0d phase", ph), 32'(phase_x), 32'(ph));
         chk($sformatf("b lda ph%0d ctl", ph), 32'(ctl_x), 32'(tab[0][ph]));
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2);
         #1;
         chk($sformatf("b lda st7 %0d phase", i), 32'(phase_x), 32'd7);
         chk($sformatf("b lda st7 %0d ctl", i), 32'(ctl_x), 32'h082);
         chk($sformatf("b lda st7 %0d cnt", i), 32'(cnt_x), 32'd0);
         @(negedge clk);
      end
      #1;
      chk("b lda end phase", 32'(phase_x), 32'd0);
      chk("b lda end cnt", 32'(cnt_x), 32'd1);

      // JMP phase 7 is not a stall point
      do_instr(3'd7, 2, 8, 8'h7F, "b jmp");
      #1;
      chk("b jmp end phase", 32'(phase_x), 32'd0);
      chk("b jmp end cnt", 32'(cnt_x), 32'd2);

      // STO stalls one cycle at phase 7
      do_instr(3'd6, 1, 7, 8'hFF, "b sto");
      mem_ready = 1'b0;
      #1;
      chk("b sto st7 phase", 32'(phase_x), 32'd7);
      chk("b sto st7 ctl", 32'(ctl_x), 32'h005);
      @(negedge clk);
      mem_ready = 1'b1;
      #1 chk("b sto hold phase", 32'(phase_x), 32'd7);
      @(negedge clk);
      #1;
      chk("b sto end phase", 32'(phase_x), 32'd0);
      chk("b sto end cnt", 32'(cnt_x), 32'd3);

      // Asynchronous reset in phase 5 of an ADD
      do_instr(3'd2, 0, 5, 8'hFF, "b add");
      #1 chk("b add ph5 phase", 32'(phase_x), 32'd5);
      rst_b = 1'b0;
      #1;
      chk("b arst phase", 32'(phase_x), 32'd0);
      chk("b arst halted", 32'(halted_x), 32'd1);
      chk("b arst ctl", 32'(ctl_x), 32'd0);
      chk("b arst cnt", 32'(cnt_x), 32'd0);

      // Two-bit counter wraps after four retirements
      cur = 2;
      @(negedge clk);
      rst_c = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         do_instr(3'd7, 2, 8, 8'hFF, $sformatf("c jmp%0d", n));
         #1 chk($sformatf("c cnt after %0d", n), 32'(cnt_x), 32'(n % 4));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
